// File: rtl/recv_frame_timer.sv
// Receive frame timer: tracks frame markers, locks onto the 32-slot frame cadence,
// flywheels through missing markers and reports per-sync phase error and slot strobes.
module recv_frame_timer #(
  parameter int DIV_CODE_10US = 1299,
  parameter int TOL           = 8,
  parameter int LOCK_CNT      = 3,
  parameter int MISS_MAX      = 4
) (
  input  logic       sysclk,
  input  logic       nrst,
  input  logic       frm_sync,
  output logic       locked,
  output logic [1:0] state,
  output logic [4:0] slot_idx,
  output logic       slot_stb,
  output logic       tri_6k,
  output logic       tri_3k,
  output logic       ph_vld,
  output logic [7:0] phase_err,
  output logic       sync_err
);

  localparam int CW = (DIV_CODE_10US < 1) ? 1 : $clog2(DIV_CODE_10US + 1);
  localparam logic [CW-1:0] CH_MAX = CW'(DIV_CODE_10US);
  localparam logic [CW-1:0] WIN_LO = CW'(DIV_CODE_10US - TOL);
  localparam logic [CW-1:0] CH_TOL = CW'(TOL);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2,
    FLY   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] chCnt_q, chCnt_d;
  logic [4:0]    slotIdx_q, slotIdx_d;
  logic [2:0]    goodCnt_q, goodCnt_d;
  logic [3:0]    missCnt_q, missCnt_d;
  logic          winUsed_q, winUsed_d;
  logic [7:0]    phase_q, phase_d;
  logic          phVld_q, phVld_d;
  logic          syncErr_q, syncErr_d;

  logic          inWin;
  logic          closePt;
  logic          missEvt;
  logic          takeSync;
  logic          straySync;
  logic          realign;
  logic [7:0]    offset8;
  logic          stb;
  logic          lockedInt;

  always_ff @(posedge sysclk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= HUNT;
      chCnt_q   <= '0;
      slotIdx_q <= '0;
      goodCnt_q <= '0;
      missCnt_q <= '0;
      winUsed_q <= 1'b0;
      phase_q   <= '0;
      phVld_q   <= 1'b0;
      syncErr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chCnt_q   <= chCnt_d;
      slotIdx_q <= slotIdx_d;
      goodCnt_q <= goodCnt_d;
      missCnt_q <= missCnt_d;
      winUsed_q <= winUsed_d;
      phase_q   <= phase_d;
      phVld_q   <= phVld_d;
      syncErr_q <= syncErr_d;
    end
  end

  // The window straddles the frame boundary; winUsed marks that a sync already
  // claimed the current window, so later ones in it are silently dropped.
  always_comb begin
    inWin     = ((slotIdx_q == 5'd31) && (chCnt_q >= WIN_LO)) ||
                ((slotIdx_q == 5'd0) && (chCnt_q < CH_TOL));
    closePt   = (slotIdx_q == 5'd0) && (chCnt_q == CH_TOL);
    missEvt   = closePt && !winUsed_q;
    takeSync  = frm_sync && inWin && !winUsed_q;
    straySync = frm_sync && !inWin;
    if (slotIdx_q == 5'd31) offset8 = 8'(chCnt_q) - 8'(DIV_CODE_10US);
    else                    offset8 = 8'(chCnt_q) + 8'd1;

    realign   = 1'b0;
    state_d   = state_q;
    goodCnt_d = goodCnt_q;
    missCnt_d = missCnt_q;
    phase_d   = phase_q;
    phVld_d   = 1'b0;
    syncErr_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (frm_sync) begin
          realign   = 1'b1;
          goodCnt_d = 3'd1;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (takeSync) begin
          realign   = 1'b1;
          phVld_d   = 1'b1;
          phase_d   = offset8;
          goodCnt_d = goodCnt_q + 3'd1;
          if (goodCnt_q + 3'd1 == 3'(LOCK_CNT)) state_d = LOCK;
        end else if (straySync) begin
          realign   = 1'b1;
          goodCnt_d = 3'd1;
        end else if (missEvt) begin
          state_d = HUNT;
        end
      end
      LOCK, FLY: begin
        if (takeSync) begin
          realign   = 1'b1;
          phVld_d   = 1'b1;
          phase_d   = offset8;
          missCnt_d = 4'd0;
          state_d   = LOCK;
        end else begin
          syncErr_d = straySync;
          if (missEvt) begin
            if (state_q == LOCK) begin
              missCnt_d = 4'd1;
              state_d   = (MISS_MAX == 1) ? HUNT : FLY;
            end else begin
              missCnt_d = missCnt_q + 4'd1;
              if (missCnt_q + 4'd1 >= 4'(MISS_MAX)) state_d = HUNT;
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (realign)      winUsed_d = 1'b1;
    else if (closePt) winUsed_d = 1'b0;
    else              winUsed_d = winUsed_q;

    if (realign) begin
      chCnt_d   = '0;
      slotIdx_d = '0;
    end else if (chCnt_q == CH_MAX) begin
      chCnt_d   = '0;
      slotIdx_d = slotIdx_q + 5'd1;
    end else begin
      chCnt_d   = chCnt_q + CW'(1);
      slotIdx_d = slotIdx_q;
    end
  end

  always_comb begin
    lockedInt = (state_q == LOCK) || (state_q == FLY);
    stb       = (chCnt_q == '0) && (state_q != HUNT);
    locked    = lockedInt;
    state     = state_q;
    slot_idx  = slotIdx_q;
    slot_stb  = stb;
    tri_6k    = stb && lockedInt && ((slotIdx_q == 5'd0) || (slotIdx_q == 5'd16));
    tri_3k    = stb && lockedInt && (slotIdx_q == 5'd0);
    ph_vld    = phVld_q;
    phase_err = phase_q;
    sync_err  = syncErr_q;
  end

endmodule

// File: doc/recv_frame_timer.md
RECV_FRAME_TIMER -- requirements
Module: recv_frame_timer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  DIV_CODE_10US, 1299, slot period is DIV_CODE_10US+1 sysclk cycles.
  TOL, 8, sync acceptance half-window in cycles; legal range 1..127.
  LOCK_CNT, 3, consecutive in-window syncs needed to lock; legal range 2..7.
  MISS_MAX, 4, consecutive missed windows that drop lock; legal range 1..15.
REQ-002 Ports, one per line (name, direction, width, meaning):
  sysclk, in, 1, system clock.
  nrst, in, 1, asynchronous active-low reset.
  frm_sync, in, 1, one-cycle pulse from the receive decoder marking a frame marker.
  locked, out, 1, high in LOCK and FLY.
  state, out, 2, HUNT=0, CHECK=1, LOCK=2, FLY=3.
  slot_idx, out, 5, current slot number 0..31.
  slot_stb, out, 1, one-cycle slot-start pulse.
  tri_6k, out, 1, pulse at slots 0 and 16.
  tri_3k, out, 1, pulse at slot 0.
  ph_vld, out, 1, pulse: phase_err updated.
  phase_err, out, 8, signed two's-complement offset of the last accepted sync.
  sync_err, out, 1, pulse: out-of-window sync while locked.

Function
REQ-003 Local counter ch_cnt SHALL count 0..DIV_CODE_10US and wrap to 0; slot_idx SHALL increment on each wrap and wrap from 31 to 0; frame length SHALL be 32*(DIV_CODE_10US+1) cycles.
REQ-004 The on-time cycle T SHALL be the cycle with slot_idx=31 and ch_cnt=DIV_CODE_10US; the window SHALL be cycles T-TOL..T+TOL (slot 31 with ch_cnt>=DIV-TOL, or slot 0 with ch_cnt<TOL).
REQ-005 An accepted sync SHALL realign: on that clock edge ch_cnt<=0 and slot_idx<=0, so the next cycle shows slot 0, ch_cnt 0.
REQ-006 Only the first sync within one window SHALL be accepted; later syncs in the same window SHALL be ignored without sync_err.
REQ-007 A miss SHALL be declared in the cycle with slot_idx=0 and ch_cnt=TOL if no sync was accepted in the window just closed.
REQ-008 HUNT: every frm_sync SHALL realign, set good_cnt=1, and go to CHECK; with no sync, counters free-run.
REQ-009 CHECK: an in-window sync SHALL realign and increment good_cnt, entering LOCK when good_cnt reaches LOCK_CNT; an out-of-window sync SHALL realign, set good_cnt=1, and stay in CHECK; a miss SHALL go to HUNT.
REQ-010 LOCK: an in-window sync SHALL realign and clear miss_cnt; an out-of-window sync SHALL NOT realign and SHALL pulse sync_err for 1 cycle; a miss SHALL set miss_cnt=1 and go to FLY, or go to HUNT if MISS_MAX=1.
REQ-011 FLY: counters SHALL free-run and outputs continue; an in-window sync SHALL realign, clear miss_cnt, and go to LOCK; a miss SHALL increment miss_cnt and go to HUNT when miss_cnt reaches MISS_MAX; an out-of-window sync SHALL behave as in LOCK.
REQ-012 phase_err SHALL equal (sync cycle position minus T) in cycles, range -TOL..+TOL; it and ph_vld SHALL be registered and valid the cycle after each accepted sync in CHECK, LOCK, or FLY.
REQ-013 slot_stb SHALL be high in cycles with ch_cnt=0 when state is not HUNT.
REQ-014 tri_6k SHALL equal slot_stb AND (slot_idx=0 or 16) AND locked; tri_3k SHALL equal slot_stb AND slot_idx=0 AND locked.
REQ-015 State transitions and the locked output SHALL take effect on the clock edge of the triggering event, so they are visible the following cycle.

Reset
REQ-016 While nrst=0, all registers SHALL clear asynchronously: state=HUNT, ch_cnt, slot_idx, good_cnt, miss_cnt, and phase_err all 0, and every output 0.
REQ-017 Deassertion of nrst mid-operation SHALL restart in HUNT with no residual lock.

Verification
REQ-018 After reset, frm_sync every 41600 cycles: state goes CHECK after sync 1, and locked=1 the cycle after sync 3, with phase_err=0.
REQ-019 Locked, one sync 5 cycles late: ph_vld=1, phase_err=+5, realigned, state stays LOCK, sync_err=0.
REQ-020 Locked, one sync at T+20: sync_err is a 1-cycle pulse, no realign, miss at window close gives FLY; next on-time sync gives LOCK.
REQ-021 Locked, syncs removed: state FLY after 1st miss, HUNT and locked=0 after 4th miss; tri_6k/tri_3k stop.
REQ-022 In LOCK: tri_6k period 20800 cycles, tri_3k period 41600 cycles, slot_stb period 1300 cycles; slot_idx wraps 31 to 0.
REQ-023 nrst pulsed low while in LOCK: all outputs 0 immediately; relock needs 3 fresh syncs.
